// File: rtl/cla_pipe_addsub.sv
// rtl/cla_pipe_addsub.sv - pipelined carry-look-ahead add/subtract unit, one GROUP-bit slice per stage
// Whole-pipe valid/ready stall; operands enter an input register, then each stage resolves one group.
module cla_pipe_addsub #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / GROUP;

  generate
    if (GROUP < 1 || (WIDTH % GROUP) != 0) begin : g_bad_params
      $error("cla_pipe_addsub: WIDTH must be a positive multiple of GROUP");
    end
  endgenerate

  // Register index k holds the operand set after k groups have been resolved.
  logic             v_q   [STAGES+1];
  logic             c_q   [STAGES+1];
  logic [WIDTH-1:0] s_q   [STAGES+1];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic             ovf_q;

  logic [GROUP-1:0] p_grp [STAGES];
  logic [GROUP-1:0] g_grp [STAGES];
  logic [GROUP:0]   cy    [STAGES];
  logic [WIDTH-1:0] s_nxt [STAGES];

  logic adv;

  // Flattened look-ahead: each carry is a sum of generate terms gated by the propagate run above it.
  function automatic logic [GROUP:0] cla(input logic [GROUP-1:0] p,
                                         input logic [GROUP-1:0] g,
                                         input logic             c0);
    logic [GROUP:0] c;
    logic           prod;
    c    = '0;
    c[0] = c0;
    for (int i = 0; i < GROUP; i++) begin
      c[i+1] = g[i];
      prod   = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (prod & g[j]);
        prod   = prod & p[j];
      end
      c[i+1] = c[i+1] | (prod & c0);
    end
    return c;
  endfunction

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = v_q[STAGES];
  assign sum       = s_q[STAGES];
  assign cout      = c_q[STAGES];
  assign ovf       = ovf_q;

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      p_grp[k] = a_q[k][k*GROUP +: GROUP] ^ b_q[k][k*GROUP +: GROUP];
      g_grp[k] = a_q[k][k*GROUP +: GROUP] & b_q[k][k*GROUP +: GROUP];
      cy[k]    = cla(p_grp[k], g_grp[k], c_q[k]);
      s_nxt[k] = s_q[k];
      s_nxt[k][k*GROUP +: GROUP] = p_grp[k] ^ cy[k][GROUP-1:0];
    end
  end

  // s_q[0] is never loaded; it is the all-zero partial sum that stage 0 fills in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= STAGES; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        s_q[k] <= '0;
      end
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
      ovf_q <= 1'b0;
    end else if (adv) begin
      v_q[0] <= in_valid;
      a_q[0] <= a;
      b_q[0] <= sub ? ~b : b;
      c_q[0] <= sub | cin;
      for (int k = 0; k < STAGES; k++) begin
        v_q[k+1] <= v_q[k];
        c_q[k+1] <= cy[k][GROUP];
        s_q[k+1] <= s_nxt[k];
      end
      for (int k = 0; k < STAGES - 1; k++) begin
        a_q[k+1] <= a_q[k];
        b_q[k+1] <= b_q[k];
      end
      ovf_q <= cy[STAGES-1][GROUP-1] ^ cy[STAGES-1][GROUP];
    end
  end

endmodule
